opto_period_stats: RTL and testbench

Parametrised successor to the single-bank code-disc cycle statistics block. It measures the clock-cycle interval between consecutive code-disc (opto) teeth over one revolution, framed by the zero-mark signal. Results go into a ping-pong buffer so the host reads a stable, complete revolution while the next one is captured. It adds per-revolution min/max/total, tooth-count checking, edge blanking and stall detection, and sits between the motor speed loop and the host register/readout logic.

---
 rtl/opto_period_stats.sv | 180 ++++++++++++++++++
 tb/tb_opto_period_stats.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/opto_period_stats.sv
// Code-disc tooth period capture per revolution into a ping-pong buffer, with
// per-revolution min/max/total, tooth-count check, edge blanking and stall detect.
module opto_period_stats #(
  parameter int unsigned N_TEETH   = 60,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned AW        = 6,
  parameter int unsigned MIN_GAP   = 16,
  parameter int unsigned STALL_CYC = 50000000
) (
  input  logic             i_clk_50m,
  input  logic             i_rst,
  input  logic             i_opto_switch,
  input  logic             i_zero_sign,
  input  logic             i_motor_state,
  input  logic [AW-1:0]    i_ram_raddr,
  input  logic             i_ram_ren,
  output logic [CNT_W-1:0] o_ram_rdata,
  output logic             o_rev_done,
  output logic             o_rev_valid,
  output logic             o_tooth_err,
  output logic             o_stall,
  output logic [7:0]       o_tooth_num,
  output logic [CNT_W-1:0] o_period_min,
  output logic [CNT_W-1:0] o_period_max,
  output logic [CNT_W-1:0] o_rev_period
);
  localparam int unsigned      DEPTH     = 2**AW;
  localparam logic [CNT_W-1:0] MIN_GAP_C = CNT_W'(MIN_GAP);
  localparam logic [CNT_W-1:0] STALL_C   = CNT_W'(STALL_CYC);
  localparam logic [7:0]       N_TEETH_C = 8'(N_TEETH);
  localparam logic [AW-1:0]    LAST_ADDR = AW'(N_TEETH);

  typedef enum logic [1:0] {IDLE, WAIT_ZERO, RUN} state_t;
  state_t state, state_nxt;

  // [0] = meta, [1] = s1, [2] = s2
  logic [2:0] opto_sync, zero_sync, motor_sync;
  logic       opto_rise, zero_rise, motor_on;

  logic [CNT_W-1:0] pcnt, rcnt, run_min, run_max;
  logic [7:0]       idx;
  logic             wsel;
  logic             ev_zero, ev_commit, ev_opto, ev_stall, ev_write;

  logic [CNT_W-1:0] mem [2*DEPTH];
  logic [AW:0]      waddr;
  logic [CNT_W-1:0] wdata;
  logic             we;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign opto_rise = opto_sync[1] & ~opto_sync[2];
  assign zero_rise = zero_sync[1] & ~zero_sync[2];
  assign motor_on  = motor_sync[2];

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      opto_sync  <= '0;
      zero_sync  <= '0;
      motor_sync <= '0;
    end else begin
      opto_sync  <= {opto_sync[1:0], i_opto_switch};
      zero_sync  <= {zero_sync[1:0], i_zero_sign};
      motor_sync <= {motor_sync[1:0], i_motor_state};
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!motor_on) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      state_nxt = WAIT_ZERO;
        WAIT_ZERO: if (zero_rise) state_nxt = RUN;
        RUN:       if (ev_stall) state_nxt = WAIT_ZERO;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Zero rise outranks a coincident opto rise; stall only fires on an otherwise idle cycle.
  always_comb begin
    ev_zero   = 1'b0;
    ev_commit = 1'b0;
    ev_opto   = 1'b0;
    ev_stall  = 1'b0;
    if (motor_on) begin
      case (state)
        WAIT_ZERO: ev_zero = zero_rise;
        RUN: begin
          ev_zero   = zero_rise;
          ev_commit = zero_rise;
          ev_opto   = opto_rise && !zero_rise && (pcnt >= MIN_GAP_C);
          ev_stall  = !zero_rise && !ev_opto && (pcnt >= STALL_C);
        end
        default: ;
      endcase
    end
  end

  assign ev_write = ev_opto && (idx < N_TEETH_C);

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      pcnt         <= '0;
      rcnt         <= '0;
      idx          <= '0;
      run_min      <= '1;
      run_max      <= '0;
      wsel         <= 1'b0;
      o_rev_done   <= 1'b0;
      o_rev_valid  <= 1'b0;
      o_tooth_err  <= 1'b0;
      o_stall      <= 1'b0;
      o_tooth_num  <= '0;
      o_period_min <= '0;
      o_period_max <= '0;
      o_rev_period <= '0;
    end else begin
      pcnt       <= (ev_zero || ev_opto) ? CNT_W'(1) : sat_inc(pcnt);
      rcnt       <= ev_zero ? CNT_W'(1) : sat_inc(rcnt);
      o_rev_done <= ev_commit;
      if (ev_zero) begin
        idx     <= '0;
        run_min <= '1;
        run_max <= '0;
      end else if (ev_opto) begin
        if (idx != 8'hFF) idx <= idx + 8'd1;
        if (ev_write) begin
          if (pcnt < run_min) run_min <= pcnt;
          if (pcnt > run_max) run_max <= pcnt;
        end
      end
      if (ev_commit) begin
        wsel         <= ~wsel;
        o_rev_valid  <= 1'b1;
        o_tooth_num  <= idx;
        o_tooth_err  <= (idx != N_TEETH_C);
        o_period_min <= run_min;
        o_period_max <= run_max;
        o_rev_period <= rcnt;
      end
      if (zero_rise)     o_stall <= 1'b0;
      else if (ev_stall) o_stall <= 1'b1;
    end
  end

  // Write port only ever targets the capture bank; the read bank is ~wsel.
  always_comb begin
    we = ev_write || ev_commit;
    if (ev_commit) begin
      waddr = {wsel, AW'(0)};
      wdata = CNT_W'(idx);
    end else begin
      waddr = {wsel, AW'(idx + 8'd1)};
      wdata = pcnt;
    end
  end

  always_ff @(posedge i_clk_50m) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      o_ram_rdata <= '0;
    end else if (i_ram_ren) begin
      if (!o_rev_valid || (i_ram_raddr > LAST_ADDR)) o_ram_rdata <= '0;
      else                                           o_ram_rdata <= mem[{~wsel, i_ram_raddr}];
    end
  end
endmodule

// File: tb/tb_opto_period_stats.sv
// Directed bench for opto_period_stats: hand-computed revolutions driven on an absolute cycle schedule.
`timescale 1ns/1ps
module tb_opto_period_stats;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        opto = 1'b0;
  logic        zero = 1'b0;
  logic        motor = 1'b0;
  logic [5:0]  raddr = '0;
  logic        ren = 1'b0;
  logic [31:0] rdata;
  logic        rev_done, rev_valid, tooth_err, stall;
  logic [7:0]  tooth_num;
  logic [31:0] pmin, pmax, rev_period;

  int cyc = 0;
  int done_cnt = 0;
  int n_cmp = 0;
  int n_mis = 0;
  int t0, t1, t2, t3, t4, ta, tb, tc;

  opto_period_stats #(
    .N_TEETH(60), .CNT_W(32), .AW(6), .MIN_GAP(16), .STALL_CYC(5000)
  ) dut (
    .i_clk_50m(clk), .i_rst(rst), .i_opto_switch(opto), .i_zero_sign(zero),
    .i_motor_state(motor), .i_ram_raddr(raddr), .i_ram_ren(ren),
    .o_ram_rdata(rdata), .o_rev_done(rev_done), .o_rev_valid(rev_valid),
    .o_tooth_err(tooth_err), .o_stall(stall), .o_tooth_num(tooth_num),
    .o_period_min(pmin), .o_period_max(pmax), .o_rev_period(rev_period)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rev_done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: observed cycle %0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Raise the selected inputs at negedge of cycle t, hold 4 cycles.
  task automatic edge_at(input int t, input logic z, input logic o);
    wait_until(t);
    if (cyc != t) begin
      n_mis++;
      $display("FAIL sched: observed cycle %0d required %0d", cyc, t);
    end
    if (z) zero = 1'b1;
    if (o) opto = 1'b1;
    repeat (4) @(negedge clk);
    zero = 1'b0;
    opto = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    raddr = a;
    ren   = 1'b1;
    @(negedge clk);
    check(tag, rdata, exp);
  endtask

  task automatic check_rev(input string tag, input int done, input int teeth, input logic err,
                           input int mn, input int mx, input int per);
    check({tag, "_done"}, done_cnt, done);
    check({tag, "_valid"}, rev_valid, 1);
    check({tag, "_teeth"}, tooth_num, teeth);
    check({tag, "_err"}, tooth_err, err);
    check({tag, "_min"}, pmin, mn);
    check({tag, "_max"}, pmax, mx);
    check({tag, "_period"}, rev_period, per);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("rst_rdata", rdata, 0);
    check("rst_done", rev_done, 0);
    check("rst_valid", rev_valid, 0);
    check("rst_err", tooth_err, 0);
    check("rst_stall", stall, 0);
    check("rst_teeth", tooth_num, 0);
    check("rst_min", pmin, 0);
    check("rst_max", pmax, 0);
    check("rst_period", rev_period, 0);
    rst = 1'b0;
    motor = 1'b1;
    repeat (10) @(negedge clk);

    // Revolution 1: 60 teeth at 1000 cycles
    t0 = cyc + 10;
    edge_at(t0, 1'b1, 1'b0);
    for (int k = 1; k <= 60; k++) edge_at(t0 + 1000 * k, 1'b0, 1'b1);
    t1 = t0 + 61000;
    edge_at(t1, 1'b1, 1'b0);
    check_rev("rev1", 1, 60, 1'b0, 1000, 1000, 61000);
    check("rev1_stall", stall, 0);
    rd("rev1_a0", 6'd0, 60);
    for (int a = 1; a <= 60; a++) rd("rev1_data", 6'(a), 1000);
    rd("rev1_a61", 6'd61, 0);
    rd("rev1_a63", 6'd63, 0);

    // Revolution 2: 62 teeth, first at 200 then 30 apart
    for (int k = 1; k <= 62; k++) edge_at(t1 + 200 + 30 * (k - 1), 1'b0, 1'b1);
    t2 = t1 + 2060;
    edge_at(t2, 1'b1, 1'b0);
    check_rev("rev2", 2, 62, 1'b1, 30, 200, 2060);
    rd("rev2_a0", 6'd0, 62);
    rd("rev2_a1", 6'd1, 200);
    rd("rev2_a60", 6'd60, 30);
    rd("rev2_a61", 6'd61, 0);

    // Revolution 3: 4 teeth at 200, glitch 5 cycles after tooth 2, ends with zero+opto together
    edge_at(t2 + 200, 1'b0, 1'b1);
    edge_at(t2 + 400, 1'b0, 1'b1);
    edge_at(t2 + 405, 1'b0, 1'b1);
    edge_at(t2 + 600, 1'b0, 1'b1);
    edge_at(t2 + 800, 1'b0, 1'b1);
    t3 = t2 + 1000;
    edge_at(t3, 1'b1, 1'b1);
    check_rev("rev3", 3, 4, 1'b1, 200, 200, 1000);
    rd("rev3_a0", 6'd0, 4);
    rd("rev3_a3", 6'd3, 200);
    rd("rev3_a4", 6'd4, 200);
    rd("rev3_a5_unwritten", 6'd5, 1000);

    // Revolution 4: first period measured from the coincident zero rise
    for (int k = 1; k <= 3; k++) edge_at(t3 + 300 * k, 1'b0, 1'b1);
    t4 = t3 + 1200;
    edge_at(t4, 1'b1, 1'b0);
    check_rev("rev4", 4, 3, 1'b1, 300, 300, 1200);
    rd("rev4_a1", 6'd1, 300);

    // Stall: no opto edge after revolution 4 commits
    wait_until(t4 + 4900);
    check("stall_early", stall, 0);
    wait_until(t4 + 5100);
    check("stall_set", stall, 1);
    check("stall_done", done_cnt, 4);
    check("stall_teeth", tooth_num, 3);
    rd("stall_a1", 6'd1, 300);
    ta = t4 + 5200;
    edge_at(ta, 1'b1, 1'b0);
    check("stall_clear", stall, 0);
    check("stall_nocommit", done_cnt, 4);

    // Revolution A: 5 teeth at 800
    for (int k = 1; k <= 5; k++) edge_at(ta + 800 * k, 1'b0, 1'b1);
    tb = ta + 4800;
    edge_at(tb, 1'b1, 1'b0);
    check_rev("revA", 5, 5, 1'b1, 800, 800, 4800);
    rd("revA_a5", 6'd5, 800);

    // Revolution B: 5 teeth at 900, addr 5 read every cycle across the commit
    for (int k = 1; k <= 5; k++) edge_at(tb + 900 * k, 1'b0, 1'b1);
    wait_until(tb + 5400);
    zero = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("swap_rdata", rdata, (k <= 3) ? 800 : 900);
      if (k == 2) check("swap_done_pre", rev_done, 0);
      if (k == 3) check("swap_done", rev_done, 1);
    end
    zero = 1'b0;
    check_rev("revB", 6, 5, 1'b1, 900, 900, 5400);

    ren = 1'b0;
    raddr = 6'd0;
    repeat (2) @(negedge clk);
    check("hold_rdata", rdata, 900);

    // Revolution C: motor drops mid-revolution, later zero rise must not commit
    tc = tb + 5400;
    edge_at(tc + 500, 1'b0, 1'b1);
    wait_until(tc + 700);
    motor = 1'b0;
    edge_at(tc + 1000, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("drop_done", done_cnt, 6);
    check("drop_valid", rev_valid, 1);
    check("drop_teeth", tooth_num, 5);
    check("drop_period", rev_period, 5400);
    rd("drop_a5", 6'd5, 900);
    rd("drop_a1", 6'd1, 900);

    // Reset mid-operation clears everything
    motor = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("rst2_valid", rev_valid, 0);
    check("rst2_teeth", tooth_num, 0);
    check("rst2_period", rev_period, 0);
    check("rst2_rdata", rdata, 0);
    rst = 1'b0;
    rd("rst2_read", 6'd5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
